// File: rtl/serial_word_capture.sv
// serial_word_capture: LSB-first serial bit stream into BITS lane registers, word handed off via valid/ready.
// Define SERIAL_WORD_CAPTURE_PARITY_EN to append and check an even-parity bit after each word.
module serial_word_capture #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ser_valid,
    input  logic            ser_bit,
    output logic            ser_ready,
    output logic [BITS-1:0] data,
    output logic            data_valid,
    input  logic            data_ready,
    output logic            parity_err
);
    localparam int CNT_W = $clog2(BITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
    localparam logic [1:0] S_PAR   = 2'd2;
`endif
    localparam logic [1:0] S_FULL  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(BITS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_valid_q, data_valid_d;
    logic             accept;
    logic             shift_en;

    assign ser_ready  = (state_q != S_FULL);
    assign data_valid = data_valid_q;
    assign accept     = ser_valid && ser_ready;
    assign shift_en   = accept && ((state_q == S_IDLE) || (state_q == S_SHIFT));

`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
    logic parity_err_q, parity_err_d;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_valid_d = data_valid_q;
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_SHIFT: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = CNT_DONE;
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d      = S_FULL;
                        data_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_SHIFT;
                    end
                end
            end
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
            S_PAR: begin
                // Even parity: the lanes plus the parity bit must XOR to zero.
                if (accept) begin
                    if (((^data) ^ ser_bit) == 1'b0) begin
                        state_d      = S_FULL;
                        data_valid_d = 1'b1;
                    end else begin
                        state_d      = S_IDLE;
                        cnt_d        = '0;
                        parity_err_d = 1'b1;
                    end
                end
            end
`endif
            S_FULL: begin
                if (data_valid_q && data_ready) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    data_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                data_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_valid_q <= data_valid_d;
        end
    end

`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`endif

    // One lane per bit; lanes are never cleared between words, only overwritten.
    genvar i;
    generate
        for (i = 0; i < BITS; i = i + 1) begin : g_lane
            logic lane_d;
            logic lane_q;

            always_comb begin
                lane_d = lane_q;
                if (shift_en && (cnt_q == CNT_W'(i))) begin
                    lane_d = ser_bit;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= 1'b0;
                end else begin
                    lane_q <= lane_d;
                end
            end

            assign data[i] = lane_q;
        end
    endgenerate

`ifdef FORMAL
    a_valid_blocks_serial: assert property (@(posedge clk) disable iff (!rst_n)
        data_valid |-> !ser_ready);
    a_data_held: assert property (@(posedge clk) disable iff (!rst_n)
        (data_valid && !data_ready) |=> ($stable(data) && data_valid));
`endif

endmodule
